// File: rtl/bk_kbd_pkg.sv
// Shared constants and types for the BK-0010 PS/2 keyboard front end.
package bk_kbd_pkg;

    localparam logic [7:0] PfxBrk = 8'hF0;
    localparam logic [7:0] PfxExt = 8'hE0;
    localparam logic [7:0] PfxE1  = 8'hE1;

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StSkip
    } dec_state_e;

    localparam logic [7:0] VecKbd = 8'o060;
    localparam logic [7:0] VecAr2 = 8'o274;

    function automatic logic [7:0] irq_vector(input logic ar2);
        return ar2 ? VecAr2 : VecKbd;
    endfunction

endpackage

// File: rtl/kbd_transl.sv
// Combinational PS/2 set-2 make code to BK-0010 character code lookup.
module kbd_transl (
    input  logic [7:0] code,
    input  logic       shift,
    output logic [6:0] ascii,
    output logic       autoar2
);

    logic [6:0] base;

    always_comb begin
        base    = 7'h00;
        autoar2 = 1'b0;
        case (code)
            8'h1C: base = 7'h61;  8'h32: base = 7'h62;  8'h21: base = 7'h63;
            8'h23: base = 7'h64;  8'h24: base = 7'h65;  8'h2B: base = 7'h66;
            8'h34: base = 7'h67;  8'h33: base = 7'h68;  8'h43: base = 7'h69;
            8'h3B: base = 7'h6A;  8'h42: base = 7'h6B;  8'h4B: base = 7'h6C;
            8'h3A: base = 7'h6D;  8'h31: base = 7'h6E;  8'h44: base = 7'h6F;
            8'h4D: base = 7'h70;  8'h15: base = 7'h71;  8'h2D: base = 7'h72;
            8'h1B: base = 7'h73;  8'h2C: base = 7'h74;  8'h3C: base = 7'h75;
            8'h2A: base = 7'h76;  8'h1D: base = 7'h77;  8'h22: base = 7'h78;
            8'h35: base = 7'h79;  8'h1A: base = 7'h7A;
            8'h16: base = 7'h31;  8'h1E: base = 7'h32;  8'h26: base = 7'h33;
            8'h25: base = 7'h34;  8'h2E: base = 7'h35;  8'h36: base = 7'h36;
            8'h3D: base = 7'h37;  8'h3E: base = 7'h38;  8'h46: base = 7'h39;
            8'h45: base = 7'h30;  8'h29: base = 7'h20;
            8'h5A: base = 7'o012; 8'h0D: base = 7'o011;
            8'h6B: base = 7'o010; 8'h74: base = 7'o031;
            8'h75: base = 7'o032; 8'h72: base = 7'o033;
            // F1 stands in for the BK AR2 key.
            8'h05: begin base = 7'o001; autoar2 = 1'b1; end
            default: base = 7'h00;
        endcase
        ascii = base;
        if (shift && base >= 7'h61 && base <= 7'h7A) begin
            ascii = base ^ 7'h20;
        end else if (shift && base >= 7'h31 && base <= 7'h39) begin
            ascii = base ^ 7'h10;
        end
    end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// PS/2 scan-code sequencer feeding kbd_transl, with the BK-0010 keyboard
// data/status registers, IRQ, overrun and key-down flags.
module kbd_scan_ctrl
    import bk_kbd_pkg::*;
#(
    parameter logic [7:0]  SHIFT_L = 8'h12,
    parameter logic [7:0]  SHIFT_R = 8'h59,
    parameter int unsigned E1_SKIP = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    input  logic       rd_data,
    input  logic       wr_status,
    input  logic       wr_mask,
    output logic [6:0] kbd_data,
    output logic       kbd_ready,
    output logic       int_mask,
    output logic       irq,
    output logic       irq_ar2,
    output logic       overrun,
    output logic       key_down
);

    localparam int unsigned CntW = (E1_SKIP > 1) ? $clog2(E1_SKIP) : 1;

    dec_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           shl_q, shl_d, shr_q, shr_d;
    logic [7:0]     last_make_q, last_make_d;
    logic           key_down_q, key_down_d;
    logic [7:0]     trans_code_q, trans_code_d;
    logic           trans_shift_q, trans_shift_d;
    logic           pend_q, pend_d;
    logic [6:0]     kbd_data_q, kbd_data_d;
    logic           kbd_ready_q, kbd_ready_d;
    logic           int_mask_q, int_mask_d;
    logic           irq_ar2_q, irq_ar2_d;
    logic           overrun_q, overrun_d;
    logic           make;
    logic [6:0]     ascii;
    logic           autoar2;

    kbd_transl u_transl (
        .code    (trans_code_q),
        .shift   (trans_shift_q),
        .ascii   (ascii),
        .autoar2 (autoar2)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shl_d         = shl_q;
        shr_d         = shr_q;
        last_make_d   = last_make_q;
        key_down_d    = key_down_q;
        trans_code_d  = trans_code_q;
        trans_shift_d = trans_shift_q;
        make          = 1'b0;
        if (scan_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (scan_code == PfxBrk)       state_d = StBrk;
                    else if (scan_code == PfxExt)  state_d = StExt;
                    else if (scan_code == PfxE1) begin
                        state_d = StSkip;
                        cnt_d   = CntW'(E1_SKIP - 1);
                    end
                    else if (scan_code == SHIFT_L) shl_d = 1'b1;
                    else if (scan_code == SHIFT_R) shr_d = 1'b1;
                    else                           make  = 1'b1;
                end
                StExt: begin
                    state_d = StIdle;
                    if (scan_code == PfxBrk) state_d = StExtBrk;
                    // E0 12 / E0 59 are fake shifts emitted around extended keys.
                    else if (scan_code != SHIFT_L && scan_code != SHIFT_R) make = 1'b1;
                end
                StBrk, StExtBrk: begin
                    state_d = StIdle;
                    if (scan_code == SHIFT_L)          shl_d      = 1'b0;
                    else if (scan_code == SHIFT_R)     shr_d      = 1'b0;
                    else if (scan_code == last_make_q) key_down_d = 1'b0;
                end
                StSkip: begin
                    if (cnt_q == '0) state_d = StIdle;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
        if (make) begin
            trans_code_d  = scan_code;
            trans_shift_d = shl_q | shr_q;
            key_down_d    = 1'b1;
            last_make_d   = scan_code;
        end
        pend_d = make;
    end

    always_comb begin
        kbd_data_d  = kbd_data_q;
        kbd_ready_d = kbd_ready_q;
        int_mask_d  = int_mask_q;
        irq_ar2_d   = irq_ar2_q;
        overrun_d   = overrun_q;
        if (rd_data) begin
            kbd_ready_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (pend_q && ascii != 7'h00) begin
            if (!kbd_ready_q || rd_data) begin
                kbd_data_d  = ascii;
                irq_ar2_d   = autoar2;
                kbd_ready_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (wr_status) int_mask_d = wr_mask;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            shl_q         <= 1'b0;
            shr_q         <= 1'b0;
            last_make_q   <= 8'h00;
            key_down_q    <= 1'b0;
            trans_code_q  <= 8'h00;
            trans_shift_q <= 1'b0;
            pend_q        <= 1'b0;
            kbd_data_q    <= 7'h00;
            kbd_ready_q   <= 1'b0;
            int_mask_q    <= 1'b0;
            irq_ar2_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shl_q         <= shl_d;
            shr_q         <= shr_d;
            last_make_q   <= last_make_d;
            key_down_q    <= key_down_d;
            trans_code_q  <= trans_code_d;
            trans_shift_q <= trans_shift_d;
            pend_q        <= pend_d;
            kbd_data_q    <= kbd_data_d;
            kbd_ready_q   <= kbd_ready_d;
            int_mask_q    <= int_mask_d;
            irq_ar2_q     <= irq_ar2_d;
            overrun_q     <= overrun_d;
        end
    end

    assign kbd_data  = kbd_data_q;
    assign kbd_ready = kbd_ready_q;
    assign int_mask  = int_mask_q;
    assign irq       = kbd_ready_q & ~int_mask_q;
    assign irq_ar2   = irq_ar2_q;
    assign overrun   = overrun_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Directed-vector bench for kbd_scan_ctrl with hand-computed expectations.
module tb_kbd_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       rd_data = 1'b0;
    logic       wr_status = 1'b0;
    logic       wr_mask = 1'b0;
    logic [6:0] kbd_data;
    logic       kbd_ready, int_mask, irq, irq_ar2, overrun, key_down;

    int n_checks = 0;
    int n_errors = 0;

    kbd_scan_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .rd_data    (rd_data),
        .wr_status  (wr_status),
        .wr_mask    (wr_mask),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .int_mask   (int_mask),
        .irq        (irq),
        .irq_ar2    (irq_ar2),
        .overrun    (overrun),
        .key_down   (key_down)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns #1 after the edge that samples the byte.
    task automatic send_byte(input logic [7:0] c);
        @(posedge clk);
        #1;
        scan_valid = 1'b1;
        scan_code  = c;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
    endtask

    task automatic cpu_read();
        @(posedge clk);
        #1 rd_data = 1'b1;
        @(posedge clk);
        #1 rd_data = 1'b0;
    endtask

    task automatic write_status(input logic m);
        @(posedge clk);
        #1;
        wr_status = 1'b1;
        wr_mask   = m;
        @(posedge clk);
        #1;
        wr_status = 1'b0;
        wr_mask   = 1'b0;
    endtask

    initial begin
        #12;
        check_eq("rst_data", 32'(kbd_data), 32'h0);
        check_eq("rst_ready", 32'(kbd_ready), 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        check_eq("rst_keydown", 32'(key_down), 32'h0);
        check_eq("rst_overrun", 32'(overrun), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: plain "a", latency and irq
        send_byte(8'h1C);
        check_eq("a_ready_early", 32'(kbd_ready), 32'h0);
        step(1);
        check_eq("a_ready", 32'(kbd_ready), 32'h1);
        check_eq("a_data", 32'(kbd_data), 32'h61);
        check_eq("a_irq", 32'(irq), 32'h1);
        check_eq("a_ar2", 32'(irq_ar2), 32'h0);
        check_eq("a_keydown", 32'(key_down), 32'h1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        step(2);
        check_eq("a_break_keydown", 32'(key_down), 32'h0);
        check_eq("a_break_data", 32'(kbd_data), 32'h61);
        cpu_read();
        check_eq("read_ready", 32'(kbd_ready), 32'h0);

        // 2: shifted "A", shift release while key held, then unshifted
        send_byte(8'h12);
        send_byte(8'h1C);
        step(1);
        check_eq("A_data", 32'(kbd_data), 32'h41);
        cpu_read();
        send_byte(8'hF0);
        send_byte(8'h12);
        step(2);
        check_eq("shrel_ready", 32'(kbd_ready), 32'h0);
        check_eq("shrel_keydown", 32'(key_down), 32'h1);
        send_byte(8'h1C);
        step(1);
        check_eq("a2_data", 32'(kbd_data), 32'h61);
        cpu_read();
        send_byte(8'hF0);
        send_byte(8'h1B);
        step(2);
        check_eq("other_break_keydown", 32'(key_down), 32'h1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        step(2);
        check_eq("a2_break_keydown", 32'(key_down), 32'h0);

        // 3: extended keys
        send_byte(8'hE0);
        send_byte(8'h75);
        step(1);
        check_eq("up_data", 32'(kbd_data), 32'o032);
        check_eq("up_keydown", 32'(key_down), 32'h1);
        cpu_read();
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        step(2);
        check_eq("up_break_keydown", 32'(key_down), 32'h0);
        check_eq("up_break_ready", 32'(kbd_ready), 32'h0);
        send_byte(8'hE0);
        send_byte(8'h12);
        send_byte(8'h1C);
        step(1);
        check_eq("fakeshift_data", 32'(kbd_data), 32'h61);
        cpu_read();

        // 4: overrun, then read coinciding with a load
        send_byte(8'h16);
        send_byte(8'h1E);
        step(1);
        check_eq("ovr_data", 32'(kbd_data), 32'h31);
        check_eq("ovr_flag", 32'(overrun), 32'h1);
        send_byte(8'h1E);
        rd_data = 1'b1;
        @(posedge clk);
        #1 rd_data = 1'b0;
        check_eq("rdload_data", 32'(kbd_data), 32'h32);
        check_eq("rdload_ready", 32'(kbd_ready), 32'h1);
        check_eq("rdload_overrun", 32'(overrun), 32'h0);
        cpu_read();
        check_eq("rd_ready", 32'(kbd_ready), 32'h0);
        check_eq("rd_overrun", 32'(overrun), 32'h0);

        // 5: AR2 and interrupt masking
        write_status(1'b1);
        check_eq("mask_set", 32'(int_mask), 32'h1);
        send_byte(8'h05);
        step(1);
        check_eq("ar2_flag", 32'(irq_ar2), 32'h1);
        check_eq("ar2_ready", 32'(kbd_ready), 32'h1);
        check_eq("ar2_irq_masked", 32'(irq), 32'h0);
        write_status(1'b0);
        check_eq("ar2_irq", 32'(irq), 32'h1);
        check_eq("ar2_data_kept", 32'(kbd_data), 32'o001);
        cpu_read();

        // 6: Pause sequence swallowed, then decoder back in idle
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        step(2);
        check_eq("pause_ready", 32'(kbd_ready), 32'h0);
        send_byte(8'h1C);
        step(1);
        check_eq("post_pause_data", 32'(kbd_data), 32'h61);

        // reset mid-prefix with a character pending
        send_byte(8'hE0);
        reset_n = 1'b0;
        #3;
        check_eq("midrst_data", 32'(kbd_data), 32'h0);
        check_eq("midrst_ready", 32'(kbd_ready), 32'h0);
        check_eq("midrst_keydown", 32'(key_down), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        send_byte(8'h1C);
        step(1);
        check_eq("after_rst_data", 32'(kbd_data), 32'h61);
        cpu_read();

        // reset mid-SKIP abandons the remaining skip count
        send_byte(8'hE1);
        send_byte(8'h14);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        send_byte(8'h1C);
        step(1);
        check_eq("skip_rst_ready", 32'(kbd_ready), 32'h1);
        check_eq("skip_rst_data", 32'(kbd_data), 32'h61);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
